fxp_add_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one `unsigned_pipelined_fixed_point_adder` (Q4.4 + Q4.4 → Q5.4, unsigned) among `N_REQ` requesters. It accepts at most one operand pair per cycle over valid/ready and drives the adder's A/B inputs. A requester-ID tag travels alongside the adder pipeline, so each 9-bit sum comes back tagged with the requester that issued it. The block sits between the requesting datapath units and the shared adder.

---
 rtl/fxp_pkg.sv | 16 +
 rtl/fxp_rr_arbiter.sv | 47 ++++
 rtl/unsigned_pipelined_fixed_point_adder.sv | 25 ++
 rtl/fxp_add_rr_scheduler.sv | 82 ++++++++
 tb/tb_fxp_add_rr_scheduler.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point types and helpers for the Q4.4 adder datapath.
package fxp_pkg;

  localparam int FXP_IN_W   = 8;
  localparam int FXP_OUT_W  = 9;
  localparam int FXP_FRAC_W = 4;

  typedef logic [FXP_IN_W-1:0]  fxp_q44_t;
  typedef logic [FXP_OUT_W-1:0] fxp_q54_t;

  // Unsigned Q4.4 + Q4.4 with one carry bit of headroom; cannot overflow.
  function automatic fxp_q54_t fxp_add(input fxp_q44_t a, input fxp_q44_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/fxp_rr_arbiter.sv
// Round-robin arbiter: combinational grant, priority rotates past the last
// granted index only when the grant is actually consumed (advance).
module fxp_rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last_gnt;

  // Search from last_gnt+1 with wrap; no grant at all while in reset.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] ci;
    int unsigned      cand;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    ci      = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_gnt) + k) % N;
      ci   = IDX_W'(cand);
      if (!rst && !found && req[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        gnt_idx = ci;
      end
    end
  end

  // Priority pointer: requester 0 is searched first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= IDX_W'(N - 1);
    end else if (advance) begin
      last_gnt <= gnt_idx;
    end
  end

endmodule

// File: rtl/unsigned_pipelined_fixed_point_adder.sv
// Unsigned Q4.4 + Q4.4 -> Q5.4 adder, LATENCY register stages, no reset.
module unsigned_pipelined_fixed_point_adder
  import fxp_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] sum
);

  fxp_q54_t pipe [LATENCY];

  // Sum is formed at the input stage, then delayed to the full latency.
  always_ff @(posedge clk) begin
    pipe[0] <= fxp_add(a, b);
    for (int unsigned s = 1; s < LATENCY; s++) begin
      pipe[s] <= pipe[s-1];
    end
  end

  assign sum = pipe[LATENCY-1];

endmodule

// File: rtl/fxp_add_rr_scheduler.sv
// Round-robin sharing of one pipelined Q4.4 adder among N_REQ requesters;
// a requester-ID tag rides alongside the adder so each sum returns tagged.
module fxp_add_rr_scheduler
  import fxp_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int ADD_LAT = 2,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*8-1:0]    req_a,
  input  logic [N_REQ*8-1:0]    req_b,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [FXP_OUT_W-1:0]  rsp_sum,
  output logic                  busy
);

  logic [ID_W-1:0]  gnt_idx;
  logic             transfer;
  fxp_q44_t         add_a;
  fxp_q44_t         add_b;
  logic [ADD_LAT-1:0] tag_vld;
  logic [ID_W-1:0]  tag_id [ADD_LAT];

  assign transfer = |(req_valid & req_ready);

  fxp_rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (transfer),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  // Operand mux: granted lane on a transfer, zeros otherwise.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (transfer) begin
      add_a = req_a[32'(gnt_idx)*FXP_IN_W +: FXP_IN_W];
      add_b = req_b[32'(gnt_idx)*FXP_IN_W +: FXP_IN_W];
    end
  end

  unsigned_pipelined_fixed_point_adder #(
    .LATENCY (ADD_LAT)
  ) u_add (
    .clk (clk),
    .a   (add_a),
    .b   (add_b),
    .sum (rsp_sum)
  );

  // Tag shift register mirroring the adder pipeline; reset drops in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int unsigned s = 0; s < ADD_LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_vld[0] <= transfer;
      tag_id[0]  <= gnt_idx;
      for (int unsigned s = 1; s < ADD_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  assign rsp_valid = tag_vld[ADD_LAT-1];
  assign rsp_id    = tag_id[ADD_LAT-1];
  assign busy      = |tag_vld;

endmodule

// File: tb/tb_fxp_add_rr_scheduler.sv
// Bench for fxp_add_rr_scheduler: table-driven grant/busy vectors, a
// scoreboard of expected tagged sums, and a hand-written reset-mid-flight run.
module tb_fxp_add_rr_scheduler;

  localparam int N_REQ   = 4;
  localparam int ADD_LAT = 2;
  localparam int ID_W    = 2;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*8-1:0] req_a;
  logic [N_REQ*8-1:0] req_b;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [8:0]         rsp_sum;
  logic               busy;

  fxp_add_rr_scheduler #(
    .N_REQ   (N_REQ),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic armed = 1'b0;

  typedef struct {
    int         id;
    logic [8:0] sum;
    int         due;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  er;
    logic        cb;
    logic        eb;
  } vec_t;
  vec_t vecs[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // One cycle: drive at the falling edge, check grant/busy, record the
  // expected response, then clock; a reset cycle discards pending responses.
  task automatic step(input string nm, input logic r, input logic [3:0] v,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] er, input logic cb, input logic eb);
    exp_t e;
    logic [7:0] la, lb;
    rst = r; req_valid = v; req_a = a; req_b = b;
    #1;
    chk({nm, "_ready"}, 32'(req_ready), 32'(er));
    if (cb) chk({nm, "_busy"}, 32'(busy), 32'(eb));
    for (int i = 0; i < N_REQ; i++) begin
      if (er[i]) begin
        la = a[8*i +: 8];
        lb = b[8*i +: 8];
        e.id  = i;
        e.sum = {1'b0, la} + {1'b0, lb};
        e.due = cyc + ADD_LAT;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      sbq.delete();
      armed = 1'b1;
    end
    @(negedge clk);
  endtask

  // Scoreboard: every response must match the oldest expectation exactly on time.
  always @(negedge clk) begin
    exp_t e;
    if (armed && rsp_valid !== 1'b0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fa, fb;
    fa = {8'h40, 8'h00, 8'h11, 8'h7F};
    fb = {8'h05, 8'h00, 8'h22, 8'h01};
    // reset holds off grants even with all requesters valid
    vecs[0]  = '{1'b1, 4'b1111, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0};
    // single request on lane 2: 0x0F + 0x0F = 0x01E
    vecs[2]  = '{1'b0, 4'b0100, 32'h000F0000, 32'h000F0000, 4'b0100, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0};
    // fresh reset, then full contention rotates 0,1,2,3,0
    vecs[6]  = '{1'b1, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 32'h18181818, 32'h18181818, 4'b0001, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 32'h18181818, 32'h18181818, 4'b0010, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 32'h18181818, 32'h18181818, 4'b0100, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 32'h18181818, 32'h18181818, 4'b1000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, 32'h18181818, 32'h18181818, 4'b0001, 1'b0, 1'b0};
    // boundary sums
    vecs[12] = '{1'b0, 4'b0010, 32'h0000F000, 32'h00001000, 4'b0010, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'b0100, 32'h00FF0000, 32'h00FF0000, 4'b0100, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'b1000, 32'h0, 32'h0, 4'b1000, 1'b0, 1'b0};
    // partial contention 1/3, requester 0 joins mid-stream
    vecs[15] = '{1'b0, 4'b1010, fa, fb, 4'b0010, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 4'b1011, fa, fb, 4'b1000, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 4'b1011, fa, fb, 4'b0001, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 4'b1011, fa, fb, 4'b0010, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 4'b1011, fa, fb, 4'b1000, 1'b0, 1'b0};
    // lane 2 loses to lane 1 then withdraws; busy falls ADD_LAT after last transfer
    vecs[20] = '{1'b0, 4'b0110, 32'h00011100, 32'h00022200, 4'b0010, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1};
    vecs[22] = '{1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1};
    vecs[23] = '{1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      step($sformatf("v%0d", i), vecs[i].r, vecs[i].v, vecs[i].a, vecs[i].b,
           vecs[i].er, vecs[i].cb, vecs[i].eb);
    end

    // Reset mid-flight: two transfers, reset before the second one returns.
    step("mf_t0", 1'b0, 4'b1111, 32'h03030303, 32'h04040404, 4'b0100, 1'b0, 1'b0);
    step("mf_t1", 1'b0, 4'b1111, 32'h03030303, 32'h04040404, 4'b1000, 1'b0, 1'b0);
    step("mf_rst", 1'b1, 4'b1111, 32'h03030303, 32'h04040404, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_rsp_id", 32'(rsp_id), 32'd0);
    step("mf_idle0", 1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0);
    step("mf_idle1", 1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0);
    step("mf_next", 1'b0, 4'b1111, 32'h03030303, 32'h04040404, 4'b0001, 1'b1, 1'b0);
    step("drain0", 1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
    step("drain1", 1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
    step("drain2", 1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
